// File: rtl/uart_cfg_pkg.sv
// Shared types and constants for the uart_cfg block.
// Parity support is built only when UART_CFG_PARITY_EN is defined.
package uart_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int OVERSAMPLE_LO = 8;
  localparam int OVERSAMPLE_HI = 16;

  function automatic int calc_div(
    input int clock_rate,
    input int baud_rate,
    input int oversample
  );
    int d;
    d = clock_rate / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick shared by the TX and RX paths.
// One-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART transmitter/receiver with handshake ports.
// Define UART_CFG_PARITY_EN to add one parity bit per frame.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 rx_en,
  input  logic                 tx_en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int CW = 6;
  localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] OS_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      (OVERSAMPLE != OVERSAMPLE_LO && OVERSAMPLE != OVERSAMPLE_HI) ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_cfg: parameter out of legal range");
  end

  logic tick;

  uart_baud_tick #(
    .DIV(calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE))
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  state_t               tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [CW-1:0]        tx_cnt;
  logic [3:0]           tx_bit;
  logic                 tx_arm;

  assign tx_ready = run && tx_en && (tx_state == IDLE);
  assign tx_busy  = (tx_state != IDLE);

`ifdef UART_CFG_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic tx_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     tx_par <= 1'b0;
    else if (tx_ready && tx_valid)  tx_par <= ^tx_data ^ ODD;
  end
`endif

  // START waits for the first tick (tx_arm) so every bit spans whole ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_arm   <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (tx_state)
        IDLE: if (tx_ready && tx_valid) begin
          tx_shift <= tx_data;
          tx_arm   <= 1'b0;
          tx_state <= START;
        end
        START: if (tick) begin
          if (!tx_arm) begin
            tx_arm <= 1'b1;
            tx     <= 1'b0;
            tx_cnt <= '0;
          end else if (tx_cnt == OS_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: if (tick) begin
          if (tx_cnt != OS_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            if (tx_bit != BIT_LAST) begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end else begin
`ifdef UART_CFG_PARITY_EN
              tx       <= tx_par;
              tx_state <= PARITY;
`else
              tx       <= 1'b1;
              tx_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_CFG_PARITY_EN
        PARITY: if (tick) begin
          if (tx_cnt != OS_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt   <= '0;
            tx       <= 1'b1;
            tx_state <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          if (tx_cnt != STOP_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt   <= '0;
            tx_done  <= 1'b1;
            tx_state <= IDLE;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  logic [1:0] sync;
  logic       rx_s;
  logic       rx_prev;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 keep;

  assign rx_busy = (rx_state != IDLE);
  assign keep    = rx_valid && !rx_ack;

`ifdef UART_CFG_PARITY_EN
  logic rx_par;
  logic par_err;
`else
  assign rx_parity_err = 1'b0;
`endif

  // a completing frame overrides an ack in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      rx_par       <= 1'b0;
      par_err      <= 1'b0;
`endif
    end else begin
      if (rx_valid && rx_ack) begin
        rx_valid     <= 1'b0;
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
`ifdef UART_CFG_PARITY_EN
        par_err      <= 1'b0;
`endif
      end
      unique case (rx_state)
        IDLE: if (rx_en && rx_prev && !rx_s) begin
          rx_cnt   <= '0;
          rx_state <= START;
        end
        START: if (tick) begin
          if (rx_cnt != OS_MID) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else if (rx_s) begin
            rx_state <= IDLE;
          end else begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= DATA;
          end
        end
        DATA: if (tick) begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 1'b1;
`ifdef UART_CFG_PARITY_EN
            if (rx_bit == BIT_LAST) rx_state <= PARITY;
`else
            if (rx_bit == BIT_LAST) rx_state <= STOP;
`endif
          end
        end
`ifdef UART_CFG_PARITY_EN
        PARITY: if (tick) begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_par   <= rx_s;
            rx_state <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt       <= '0;
            rx_state     <= IDLE;
            rx_data      <= rx_shift;
            rx_valid     <= 1'b1;
            rx_frame_err <= (keep & rx_frame_err) | !rx_s;
            rx_overrun   <= keep;
`ifdef UART_CFG_PARITY_EN
            par_err      <= (keep & par_err) |
                            (^rx_shift ^ ODD ^ rx_par);
`endif
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

`ifdef UART_CFG_PARITY_EN
  assign rx_parity_err = par_err;
`endif

endmodule
